// File: rtl/stage_execute_md_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: op-code width and encodings.
package stage_execute_md_pkg;

  localparam int unsigned MD_OP_LEN = 3;

  localparam logic [MD_OP_LEN-1:0] MD_OP_NONE  = 3'd0;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULT  = 3'd1;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MULTU = 3'd2;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIV   = 3'd3;
  localparam logic [MD_OP_LEN-1:0] MD_OP_DIVU  = 3'd4;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTHI  = 3'd5;
  localparam logic [MD_OP_LEN-1:0] MD_OP_MTLO  = 3'd6;

  function automatic logic is_mul_div(input logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) || (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/stage_execute_md_compute.sv
// Combinational multiply/divide datapath: produces {hi,lo} and a divide-by-zero flag.
module md_compute
  import stage_execute_md_pkg::*;
(
  input  logic [MD_OP_LEN-1:0] i_op,
  input  logic [31:0]          i_src0,
  input  logic [31:0]          i_src1,
  output logic [63:0]          o_result,
  output logic                 o_div_zero
);

  logic [63:0] w_sext0, w_sext1, w_prod_s, w_prod_u;
  logic        w_sgn, w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b, w_divisor, w_uq, w_ur, w_q, w_r;

  // Low 64 bits of a 64x64 product are the exact signed/unsigned 32x32 product.
  assign w_sext0  = {{32{i_src0[31]}}, i_src0};
  assign w_sext1  = {{32{i_src1[31]}}, i_src1};
  assign w_prod_s = w_sext0 * w_sext1;
  assign w_prod_u = {32'd0, i_src0} * {32'd0, i_src1};

  // Sign-magnitude division: 0x80000000 / -1 yields 0x80000000 with no overflow special case.
  assign w_sgn     = (i_op == MD_OP_DIV);
  assign w_neg_a   = w_sgn & i_src0[31];
  assign w_neg_b   = w_sgn & i_src1[31];
  assign w_mag_a   = w_neg_a ? (~i_src0 + 32'd1) : i_src0;
  assign w_mag_b   = w_neg_b ? (~i_src1 + 32'd1) : i_src1;
  assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq      = w_mag_a / w_divisor;
  assign w_ur      = w_mag_a % w_divisor;
  assign w_q       = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_r       = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    o_result   = 64'd0;
    o_div_zero = 1'b0;
    case (i_op)
      MD_OP_MULT:  o_result = w_prod_s;
      MD_OP_MULTU: o_result = w_prod_u;
      MD_OP_DIV, MD_OP_DIVU: begin
        o_result   = {w_r, w_q};
        o_div_zero = (i_src1 == 32'd0);
      end
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/stage_execute_md.sv
// Execute-stage multiply/divide unit: owns HI/LO, sequences multi-cycle ops, drives busy/stall.
module stage_execute_md
  import stage_execute_md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [MD_OP_LEN-1:0] md_op,
  input  logic [31:0]          src0,
  input  logic [31:0]          src1,
  input  logic                 cancel,
  input  logic                 md_use,
  output logic                 busy,
  output logic                 stall,
  output logic [31:0]          hi,
  output logic [31:0]          lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [63:0]     r_pend, w_pend_d;
  logic            r_div_zero, w_div_zero_d;
  logic [31:0]     r_hi, r_lo, w_hi_d, w_lo_d;

  logic [63:0]     w_result;
  logic            w_div_zero;
  logic            w_start_mul_div, w_accept, w_commit, w_is_mul;

  md_compute u_compute (
    .i_op       (md_op),
    .i_src0     (src0),
    .i_src1     (src1),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  assign busy            = (r_cnt != '0);
  assign w_start_mul_div = start && is_mul_div(md_op);
  assign stall           = md_use && (busy || w_start_mul_div);
  assign w_accept        = start && !cancel && !busy;
  assign w_is_mul        = (md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU);
  assign w_commit        = (r_cnt == CntW'(1)) && !cancel && !r_div_zero;
  assign hi              = r_hi;
  assign lo              = r_lo;

  always_comb begin
    w_cnt_d      = r_cnt;
    w_pend_d     = r_pend;
    w_div_zero_d = r_div_zero;
    w_hi_d       = r_hi;
    w_lo_d       = r_lo;
    if (cancel) begin
      w_cnt_d      = '0;
      w_pend_d     = 64'd0;
      w_div_zero_d = 1'b0;
    end else if (busy) begin
      w_cnt_d = r_cnt - CntW'(1);
      if (w_commit) begin
        w_hi_d = r_pend[63:32];
        w_lo_d = r_pend[31:0];
      end
    end else if (w_accept) begin
      if (is_mul_div(md_op)) begin
        w_cnt_d      = w_is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        w_pend_d     = w_result;
        w_div_zero_d = w_div_zero;
      end else if (md_op == MD_OP_MTHI) begin
        w_hi_d = src0;
      end else if (md_op == MD_OP_MTLO) begin
        w_lo_d = src0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_pend     <= 64'd0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_pend     <= w_pend_d;
      r_div_zero <= w_div_zero_d;
      r_hi       <= w_hi_d;
      r_lo       <= w_lo_d;
    end
  end

  // The hazard unit must never issue a new op while one is in flight.
  a_no_start_when_busy: assert property (@(posedge clk) disable iff (!reset_n) !(start && busy));

endmodule
